// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side logic.
//   rd_state_t   : reader control state (IDLE / RUN / DRAIN)
//   FIFO_RD_LAT  : cycles from a read-enable edge to data on the FIFO output
//   RD_BUF_DEPTH : entries in the reader's holding buffer
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_RD_LAT  = 1;
    localparam int RD_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rd_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
// Small circular holding buffer between the FIFO read port and the stream
// output. Words are pushed at the tail and presented from the head.
//   clk, rst     : clock, asynchronous active-high reset
//   i_push       : write i_push_data at the tail this edge
//   i_push_data  : word to store
//   i_pop        : retire the head entry this edge
//   o_head_data  : current head entry (always driven, even when empty)
//   o_count      : number of stored words
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_push,
    input  logic [Width-1:0]                       i_push_data,
    input  logic                                   i_pop,
    output logic [Width-1:0]                       o_head_data,
    output logic [$clog2(RD_BUF_DEPTH+1)-1:0]      o_count
);

    localparam int PtrW   = $clog2(RD_BUF_DEPTH);
    localparam int CountW = $clog2(RD_BUF_DEPTH + 1);

    logic [Width-1:0]  r_mem [RD_BUF_DEPTH];
    logic [PtrW-1:0]   r_head;
    logic [PtrW-1:0]   r_tail;
    logic [CountW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the storage is reset as well because the head entry is
            // visible on the output port, which must read zero out of reset.
            for (int i = 0; i < RD_BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_data;
                r_tail        <= r_tail + PtrW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PtrW'(1);
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CountW'(1);
                2'b01:   r_count <= r_count - CountW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Pops words from a synchronous FIFO (1-cycle read latency) and presents them
// as a valid/ready stream, prefetching into a 2-entry holding buffer so the
// stream sustains one word per cycle. Also counts delivered words.
//   clk, rst    : clock, asynchronous active-high reset
//   en          : level enable for new FIFO reads
//   fifo_empty  : FIFO empty flag
//   fifo_data   : FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en   : FIFO read enable (combinational)
//   m_valid     : output word valid
//   m_data      : output word (head of the holding buffer)
//   m_ready     : consumer ready; m_valid && m_ready is a fire
//   busy        : words buffered or in flight
//   words_out   : fires since reset, wraps modulo 2^CntWidth
// -----------------------------------------------------------------------------
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int Width    = 8,
    parameter int CntWidth = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                fifo_empty,
    input  logic [Width-1:0]    fifo_data,
    output logic                fifo_r_en,
    output logic                m_valid,
    output logic [Width-1:0]    m_data,
    input  logic                m_ready,
    output logic                busy,
    output logic [CntWidth-1:0] words_out
);

    localparam int OccW = $clog2(RD_BUF_DEPTH + 1);

    rd_state_t            r_state;
    rd_state_t            w_state_next;
    logic [OccW-1:0]      r_occ;          // buffered words + reads in flight
    logic [FIFO_RD_LAT-1:0] r_inflight;   // read issued on the previous edge
    logic [CntWidth-1:0]  r_words;
    logic [OccW-1:0]      w_buf_count;
    logic                 w_fire;

    assign w_fire = m_valid && m_ready;

    // A slot is free if occupancy is below depth, or one is being vacated by
    // a fire this same cycle. Reads are held off during reset so nothing
    // popped from the FIFO is lost across the reset release.
    assign fifo_r_en = en && !fifo_empty &&
                       ((r_occ < OccW'(RD_BUF_DEPTH)) || w_fire) && !rst;

    rd_skid_buf #(
        .Width(Width)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .i_push      (r_inflight[FIFO_RD_LAT-1]),
        .i_push_data (fifo_data),
        .i_pop       (w_fire),
        .o_head_data (m_data),
        .o_count     (w_buf_count)
    );

    assign m_valid   = (w_buf_count != '0);
    assign busy      = (r_occ != '0);
    assign words_out = r_words;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_occ      <= '0;
            r_inflight <= '0;
            r_words    <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            r_state    <= w_state_next;
            r_inflight <= fifo_r_en;
            case ({fifo_r_en, w_fire})
                2'b10:   r_occ <= r_occ + OccW'(1);
                2'b01:   r_occ <= r_occ - OccW'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_fire) begin
                r_words <= r_words + CntWidth'(1);
            end
        end
    end

    always_comb begin
        // NOTE: next state defaults to the current state before the case so
        // every path assigns it and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (en) w_state_next = RUN;
            end
            RUN: begin
                if (!en) w_state_next = (r_occ != '0) ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (en)                w_state_next = RUN;
                else if (r_occ == '0)  w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous FIFO. It pops words from the FIFO read port and presents them on a valid/ready output stream, so downstream consumers never handle FIFO read latency or the empty flag. It prefetches through a 2-entry holding buffer, which sustains one word per cycle while `m_ready` stays high. It sits between the FIFO read port (`r_en`, `data_out`, `empty`) and any streaming consumer, and also counts delivered words.

## Interface
- `Width`, 8, data word width; must match the FIFO `Width`
- `CntWidth`, 16, width of the delivered-word counter

- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  level enable; while low, no new FIFO reads are issued
- `fifo_empty`  in  1  FIFO `empty` flag
- `fifo_data`  in  Width  FIFO `data_out`; valid on the cycle after `fifo_r_en` was high at a rising edge
- `fifo_r_en`  out  1  FIFO read enable (combinational)
- `m_valid`  out  1  output word valid
- `m_data`  out  Width  output word
- `m_ready`  in  1  consumer accepts the word when `m_valid && m_ready` (a fire)
- `busy`  out  1  high while any word is in flight or buffered
- `words_out`  out  CntWidth  count of fires since reset; wraps modulo 2^CntWidth

## Operation
- **FIFO read latency:** fixed at 1 cycle. A read issued at edge N has its data on `fifo_data` during the cycle after N and is captured at edge N+1.
- **Occupancy:** `occ` (0..2) = words buffered + reads in flight.
- **Read issue:** `fifo_r_en = en && !fifo_empty && (occ < 2 || fire) && !rst`.
- **Occupancy update:** `occ_next = occ + fifo_r_en - fire`. It never exceeds 2 and never goes below 0.
- **Holding buffer:** 2 entries with head/tail pointers, or a skid pair.
  - Returned data is written to the tail.
  - `m_data` is always the head entry.
  - `m_valid = (buffered count != 0)`.
- **Ordering:** output order equals FIFO pop order. No word is dropped or duplicated under any `m_ready` pattern.
- **Stream rule:** once `m_valid` is high, `m_valid` and `m_data` hold until a fire.
- **State machine (`IDLE`, `RUN`, `DRAIN`):**
  - `IDLE` to `RUN` when `en`.
  - `RUN` to `DRAIN` when `!en` and `occ != 0`.
  - `RUN` to `IDLE` when `!en` and `occ == 0`.
  - `DRAIN` to `RUN` when `en`.
  - `DRAIN` to `IDLE` when `occ == 0`.
  - `DRAIN` issues no reads but still delivers buffered and in-flight words.
  - `busy = (occ != 0)`.
- **Counter:** `words_out` increments by 1 on each fire and wraps from all-ones to 0.

## Timing
- **Reset values:** `m_valid`=0, `m_data`=0, `busy`=0, `words_out`=0, `fifo_r_en`=0, state `IDLE`, `occ`=0, buffer pointers 0.
- **Reset mid-operation:**
  - Buffered and in-flight words are discarded.
  - `fifo_data` returned on the first edge after reset release is ignored.
- **First-word latency:** `en` high with FIFO non-empty at edge N-1 gives `fifo_r_en` high in the cycle before edge N, and `m_valid` high after edge N+1. That is 2 edges from the read-issue cycle to `m_valid`.
- **Throughput:** 1 word per cycle while `m_ready`=1 and the FIFO stays non-empty.
- **Simultaneous events:**
  - A fire and a data return in the same cycle leave the buffered count unchanged.
  - A fire and a read issue in the same cycle leave `occ` unchanged.
- **FIFO empty:** `fifo_r_en` is low. Words already buffered are still delivered.
- **Backpressure:** with `m_ready`=0, at most 2 words are popped from the FIFO and `fifo_r_en` stays low until a fire.

## Structure
- Shared package `fifo_pkg`:
  - reader state enum `IDLE`/`RUN`/`DRAIN`
  - `FIFO_RD_LAT` = 1
  - `RD_BUF_DEPTH` = 2
- One natural sub-module, `rd_skid_buf`: the 2-entry holding buffer with push/pop, count and head output. The top level holds the FSM, `occ` and the counter.

## Test plan
- **Basic order:** write 0,2,4,6,8 into the FIFO, then `en`=1, `m_ready`=1 → `m_data` sequence is 0,2,4,6,8 on consecutive cycles. `words_out`=5, then `busy`=0 and state `IDLE`.
- **Backpressure:** FIFO holds 10 words and `m_ready`=0 for 8 cycles → exactly 2 `fifo_r_en` pulses, and `m_data`=first word held stable. Then `m_ready`=1 → all 10 words arrive in order with no gaps after the first.
- **Empty mid-stream:** write 3 words, `en`=1, then write 2 more 5 cycles later → 5 words in order. `fifo_r_en` is never high while `fifo_empty`=1 and `m_valid` drops between the bursts.
- **Drain:** FIFO holds 20 words, `en` dropped after 4 fires with `occ`=2 → exactly 2 more words delivered, state `DRAIN`→`IDLE`, FIFO then holds 14 words.
- **Reset mid-transfer:** assert `rst` for 1 cycle while `occ`=2 → `m_valid`, `busy` and `words_out` are 0 immediately. After release with `en`=1, delivery resumes from the next unread FIFO word.
- **Counter wrap:** with `CntWidth`=4, deliver 18 words → `words_out`=2.
